mips_cpu_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit owning the HI/LO register pair for the MIPS core. It replaces the combinational product/quotient/remainder path and in-CPU HI/LO registers, which are not synthesisable at speed. It executes MULT, MULTU, DIV, DIVU in WIDTH+1 cycles and MTHI/MTLO in one cycle. A busy flag makes the CPU stall on a MFHI/MFLO or on a new mul/div issue.

---
 rtl/mips_cpu_pkg.sv | 19 +
 rtl/mips_cpu_div_step.sv | 25 ++
 rtl/mips_cpu_muldiv.sv | 142 ++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS core: mul/div opcodes and the mul/div sequencer states.
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } muldiv_state_t;

endpackage

// File: rtl/mips_cpu_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract the
// divisor if it fits, and shift the resulting quotient bit in at the bottom.
module mips_cpu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quot_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quot_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    always_comb begin
        shifted  = {rem_in[WIDTH-1:0], quot_in[WIDTH-1]};
        diff     = shifted - {1'b0, divisor};
        fits     = (shifted >= {1'b0, divisor});
        rem_out  = fits ? diff : shifted;
        quot_out = {quot_in[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit owning HI/LO; mul/div take WIDTH+1 enabled cycles.
// state | meaning
// IDLE  | accepts ops; MTHI/MTLO write directly, mul/div latch magnitudes
// CALC  | one shift-add or restoring-divide step per enabled edge
// FIX   | sign correction, HI/LO write, done pulse
module mips_cpu_muldiv
    import mips_cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    muldiv_state_t      state_q, state_d;
    muldiv_op_t         op;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     acc_hi;
    logic [WIDTH-1:0]   acc_lo, opnd, a_raw;
    logic               is_div, neg_q, neg_r, b_zero;

    logic               is_muldiv, is_div_op, signed_op, sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_rem;
    logic [WIDTH-1:0]   div_quot;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quot_s, rem_s;

    assign op = muldiv_op_t'(op_code);

    always_comb begin
        is_muldiv = (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
        is_div_op = (op == DIV) || (op == DIVU);
        signed_op = (op == MULT) || (op == DIV);
        sa        = signed_op & op_a[WIDTH-1];
        sb        = signed_op & op_b[WIDTH-1];
        // A W-bit unsigned magnitude already holds |most negative|, so no overflow here.
        mag_a     = sa ? -op_a : op_a;
        mag_b     = sb ? -op_b : op_b;
        mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, opnd} : '0);
        prod      = {acc_hi[WIDTH-1:0], acc_lo};
        prod_s    = neg_q ? -prod : prod;
        quot_s    = neg_q ? -acc_lo : acc_lo;
        rem_s     = neg_r ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
    end

    mips_cpu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in   (acc_hi),
        .quot_in  (acc_lo),
        .divisor  (opnd),
        .rem_out  (div_rem),
        .quot_out (div_quot)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (op_valid && is_muldiv) state_d = CALC;
            CALC:    if (cnt == CW'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            a_raw   <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            b_zero  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else if (clk_enable) begin
            state_q <= state_d;
            done    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (op_valid && op == MTHI) hi <= op_a;
                    if (op_valid && op == MTLO) lo <= op_a;
                    if (op_valid && is_muldiv) begin
                        busy   <= 1'b1;
                        cnt    <= '0;
                        acc_hi <= '0;
                        // Divide shifts the dividend through acc_lo; multiply shifts the multiplier.
                        acc_lo <= is_div_op ? mag_a : mag_b;
                        opnd   <= is_div_op ? mag_b : mag_a;
                        a_raw  <= op_a;
                        is_div <= is_div_op;
                        neg_q  <= sa ^ sb;
                        neg_r  <= sa;
                        b_zero <= (op_b == '0);
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        acc_hi <= div_rem;
                        acc_lo <= div_quot;
                    end else begin
                        acc_hi <= {1'b0, mul_sum[WIDTH:1]};
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (!is_div) begin
                        hi <= prod_s[2*WIDTH-1:WIDTH];
                        lo <= prod_s[WIDTH-1:0];
                    end else if (b_zero) begin
                        hi <= a_raw;
                        lo <= '1;
                    end else begin
                        hi <= rem_s;
                        lo <= quot_s;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Scoreboard bench for mips_cpu_muldiv at WIDTH=32: directed cases plus random ops
// checked against an arithmetic reference model.
module tb_mips_cpu_muldiv;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clk_enable = 1'b1;
    logic          op_valid = 1'b0;
    logic [2:0]    op_code = 3'd0;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int            checks = 0;
    int            failures = 0;
    int unsigned   cyc = 0;
    int unsigned   acc_cyc = 0;
    logic [63:0]   sb_q[$];
    logic          prev_done = 1'b0;
    logic [W-1:0]  exp_hi = '0;
    logic [W-1:0]  exp_lo = '0;

    mips_cpu_muldiv #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .op_valid   (op_valid),
        .op_code    (op_code),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (op)
            3'd0: p = sa * sb;
            3'd1: p = {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            3'd3: p = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: p = '0;
        endcase
        return p;
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every rising done pops one expected result.
    always @(negedge clk) begin
        if (done && !prev_done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                chk("result_hi", {32'b0, hi}, {32'b0, e[63:32]});
                chk("result_lo", {32'b0, lo}, {32'b0, e[31:0]});
            end
        end
        prev_done <= done;
    end

    // Called at a negedge with busy low; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [63:0] e);
        op_valid = 1'b1;
        op_code  = op;
        op_a     = a;
        op_b     = b;
        if (op <= 3'd3) sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic wait_done(input int exp_lat);
        int n = 0;
        int busy_lo = 0;
        while (!done && n < 200) begin
            if (!busy) busy_lo++;
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 64'd0, 64'd1);
        chk("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
        chk("busy_held", 64'(busy_lo), 64'd0);
        chk("busy_after_done", {63'b0, busy}, 64'd0);
    endtask

    task automatic run_muldiv(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [63:0] e);
        issue(op, a, b, e);
        wait_done(W + 1);
        exp_hi = e[63:32];
        exp_lo = e[31:0];
    endtask

    initial begin
        logic [2:0]   op;
        logic [W-1:0] a, b;
        logic [63:0]  e;
        int           dn;

        repeat (3) @(negedge clk);
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_done", {63'b0, done}, 64'd0);
        chk("reset_hi", {32'b0, hi}, 64'd0);
        chk("reset_lo", {32'b0, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_muldiv(3'd0, 32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFF_FFFFFFFE);
        // done must hold while the clock enable is low
        clk_enable = 1'b0;
        @(negedge clk);
        chk("done_frozen", {63'b0, done}, 64'd1);
        clk_enable = 1'b1;
        @(negedge clk);
        chk("done_cleared", {63'b0, done}, 64'd0);

        run_muldiv(3'd1, 32'hFFFFFFFF, 32'h00000002, 64'h00000001_FFFFFFFE);
        run_muldiv(3'd2, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD);
        run_muldiv(3'd3, 32'h00000007, 32'h00000000, 64'h00000007_FFFFFFFF);
        run_muldiv(3'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        run_muldiv(3'd2, 32'h80000005, 32'h00000000, 64'h80000005_FFFFFFFF);
        @(negedge clk);

        issue(3'd4, 32'h12345678, 32'h0, 64'd0);
        chk("mthi_hi", {32'b0, hi}, 64'h12345678);
        chk("mthi_busy", {63'b0, busy}, 64'd0);
        chk("mthi_done", {63'b0, done}, 64'd0);
        issue(3'd5, 32'h9ABCDEF0, 32'h0, 64'd0);
        chk("mtlo_lo", {32'b0, lo}, 64'h9ABCDEF0);
        chk("mtlo_hi_kept", {32'b0, hi}, 64'h12345678);
        chk("mtlo_busy", {63'b0, busy}, 64'd0);
        chk("mtlo_done", {63'b0, done}, 64'd0);
        exp_hi = 32'h12345678;
        exp_lo = 32'h9ABCDEF0;

        // MULT 3*5 with a 10-cycle enable freeze mid-CALC and an ignored issue while busy.
        issue(3'd0, 32'd3, 32'd5, 64'h00000000_0000000F);
        repeat (4) @(negedge clk);
        clk_enable = 1'b0;
        op_valid   = 1'b1;
        op_code    = 3'd1;
        op_a       = 32'hDEADBEEF;
        op_b       = 32'h00001234;
        repeat (10) @(negedge clk);
        chk("frozen_busy", {63'b0, busy}, 64'd1);
        clk_enable = 1'b1;
        repeat (3) @(negedge clk);
        op_valid = 1'b0;
        wait_done(W + 1 + 10);
        exp_hi = 32'h0;
        exp_lo = 32'hF;

        // Reset in the middle of a divide discards it.
        @(negedge clk);
        issue(3'd2, 32'd1000, 32'd7, ref_model(3'd2, 32'd1000, 32'd7));
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(sb_q.pop_back());
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_hi", {32'b0, hi}, 64'd0);
        chk("abort_lo", {32'b0, lo}, 64'd0);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort_no_done", 64'(dn), 64'd0);
        exp_hi = '0;
        exp_lo = '0;

        for (int i = 0; i < 120; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = rnd_operand();
            b  = rnd_operand();
            if (op <= 3'd3) begin
                e = ref_model(op, a, b);
                run_muldiv(op, a, b, e);
            end else begin
                issue(op, a, b, 64'd0);
                if (op == 3'd4) exp_hi = a;
                if (op == 3'd5) exp_lo = a;
                chk("rand_hi", {32'b0, hi}, {32'b0, exp_hi});
                chk("rand_lo", {32'b0, lo}, {32'b0, exp_lo});
                chk("rand_busy", {63'b0, busy}, 64'd0);
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
